aes_cmd_ctrl: RTL and testbench
===============================

AES_CMD_CTRL -- requirements
Module: aes_cmd_ctrl

Interface
REQ-001 SHALL have parameter BLK_BYTES, default 16, bytes per AES block (address step per block).
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd  in  2  bus command: 0 nop, 1 read, 2 write, 3 nop.
REQ-005 SHALL have port cmdaddr  in  16  register address.
REQ-006 SHALL have port cmddata  in  8  write data.
REQ-007 SHALL have port dataout  out  8  read data, registered.
REQ-008 SHALL have port blk_valid  out  1  block request to the AES datapath.
REQ-009 SHALL have port blk_ready  in  1  datapath accepts the request.
REQ-010 SHALL have port blk_addr  out  16  memory address of the current block.
REQ-011 SHALL have port blk_key  out  128  key register.
REQ-012 SHALL have port blk_ctr  out  128  counter value for the current block.
REQ-013 SHALL have port blk_done  in  1  one-cycle pulse: datapath finished the accepted block.

Function
REQ-014 Register map SHALL be: 0xff00 write of 0x01 = start, read = status; 0xff02-0xff03 address (LSB first); 0xff04-0xff05 length (LSB first); 0xff10-0xff1f key byte i; 0xff20-0xff2f counter byte i.
REQ-015 All register writes SHALL take effect on the edge where cmd==2; start SHALL accept only data 0x01; any other data at 0xff00 SHALL be ignored.
REQ-016 Reads SHALL return data on dataout one cycle after cmd==1; unmapped addresses and cmd 0/3 SHALL yield 0x00; status read SHALL return {6'b0, state}.
REQ-017 FSM states, encoded as status: IDLE=0, REQ=1, OPERATE=2, ADVANCE=3.
REQ-018 IDLE -> REQ on accepted start when length != 0; start with length == 0 SHALL leave the FSM in IDLE.
REQ-019 Start SHALL latch work copies: cur_addr=address, cur_ctr=counter, remaining=ceil(length/BLK_BYTES) (17-bit arithmetic, no overflow).
REQ-020 REQ SHALL hold blk_valid=1 with blk_addr, blk_ctr, blk_key stable until blk_valid&blk_ready; then -> OPERATE with blk_valid=0 on the next cycle.
REQ-021 OPERATE SHALL wait for blk_done, then -> ADVANCE; blk_done in any other state SHALL be ignored.
REQ-022 ADVANCE (one cycle) SHALL set cur_addr+=BLK_BYTES (16-bit wrap), cur_ctr+=1 (128-bit wrap), remaining-=1, and write cur_ctr+1 back to the counter register; then -> REQ if remaining>0 after the decrement, else IDLE.
REQ-023 While state != IDLE, writes to address, length, key, counter and start SHALL be ignored; reads SHALL stay serviced.
REQ-024 A counter-register write and the ADVANCE write-back SHALL never coincide, which REQ-023 guarantees.
REQ-025 Key SHALL be driven from the key register continuously; blk_addr/blk_ctr SHALL come from the work copies.

Reset
REQ-026 On rst low, immediately: state=IDLE, all registers and work copies=0, dataout=0x00, blk_valid=0.
REQ-027 Reset asserted mid-operation SHALL abandon the job; no completion is reported; the next start begins cleanly.

Structure
REQ-028 A shared package SHALL hold the state enum, cmd encodings (NOP/RD/WR), the register base addresses, and BLK_BYTES.
REQ-029 One sub-module, aes_cmd_regs (register file plus read mux), is natural; the FSM stays in aes_cmd_ctrl.

Verification
REQ-030 Write addr 0x1000, len 0x0020, key, ctr 0 then start, blk_ready=1, blk_done 3 cycles after each accept -> two requests at 0x1000/ctr 0 and 0x1010/ctr 1; status returns to 0; counter reads 0x02.
REQ-031 len=0x0011 -> exactly 2 blocks; len=0 with start -> no blk_valid, status stays 0.
REQ-032 blk_ready held low for 5 cycles -> blk_valid and payload stable throughout, status reads 1.
REQ-033 Address 0xfff0, ctr byte0..15 all 0xff, len 0x20 -> second block addr 0x0000, ctr 0.
REQ-034 Key/addr write or start during OPERATE -> ignored; read 0xff00 returns 0x02; unmapped read returns 0x00.
REQ-035 rst low during OPERATE -> blk_valid=0 and status 0 at once; a new job then runs correctly.

Source files
------------

// File: rtl/aes_cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_cmd_ctrl_pkg
// Shared definitions for the AES command controller: FSM state encoding
// (which is also the value returned by a status read), bus command codes,
// register-map base addresses and the default block size in bytes.
// ---------------------------------------------------------------------------
package aes_cmd_ctrl_pkg;

    // Bytes per AES block; also the address step between consecutive blocks.
    localparam int BLK_BYTES = 16;

    // State encoding doubles as the status register value.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_OPERATE = 2'd2,
        ST_ADVANCE = 2'd3
    } state_t;

    // Bus commands; encoding 3 is treated as a no-op.
    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2
    } cmd_t;

    localparam logic [15:0] REG_CTRL     = 16'hff00;
    localparam logic [15:0] REG_ADDR_LO  = 16'hff02;
    localparam logic [15:0] REG_ADDR_HI  = 16'hff03;
    localparam logic [15:0] REG_LEN_LO   = 16'hff04;
    localparam logic [15:0] REG_LEN_HI   = 16'hff05;
    localparam logic [15:0] REG_KEY_BASE = 16'hff10;
    localparam logic [15:0] REG_CTR_BASE = 16'hff20;

    // Only this exact value written to REG_CTRL launches a job.
    localparam logic [7:0]  START_CODE   = 8'h01;

    // True when addr falls inside the 16-byte window starting at base.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
        return addr[15:4] == base[15:4];
    endfunction

endpackage

// File: rtl/aes_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_cmd_ctrl_if
// Bundles the register bus (cmd/cmdaddr/cmddata/dataout) and the block
// request channel to the AES datapath (blk_*).
//   slave  : the controller side (consumes commands, issues block requests)
//   master : the host/datapath side
// ---------------------------------------------------------------------------
interface aes_cmd_ctrl_if;
    logic [1:0]   cmd;
    logic [15:0]  cmdaddr;
    logic [7:0]   cmddata;
    logic [7:0]   dataout;
    logic         blk_valid;
    logic         blk_ready;
    logic [15:0]  blk_addr;
    logic [127:0] blk_key;
    logic [127:0] blk_ctr;
    logic         blk_done;

    modport slave (
        input  cmd, cmdaddr, cmddata, blk_ready, blk_done,
        output dataout, blk_valid, blk_addr, blk_key, blk_ctr
    );

    modport master (
        output cmd, cmdaddr, cmddata, blk_ready, blk_done,
        input  dataout, blk_valid, blk_addr, blk_key, blk_ctr
    );
endinterface

// File: rtl/aes_cmd_regs.sv
// ---------------------------------------------------------------------------
// aes_cmd_regs
// Byte-addressed register file plus registered read mux.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   cmd_i/cmdaddr_i/cmddata_i  bus command, address, write data
//   state_i            controller state (status read, write gating)
//   ctr_wb_en_i/ctr_wb_i       counter write-back from the block advance
//   start_o            accepted start strobe (combinational, same edge)
//   addr_o/len_o/key_o/ctr_o   register contents
//   dataout_o          registered read data
// ---------------------------------------------------------------------------
module aes_cmd_regs
    import aes_cmd_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   cmd_i,
    input  logic [15:0]  cmdaddr_i,
    input  logic [7:0]   cmddata_i,
    input  state_t       state_i,
    input  logic         ctr_wb_en_i,
    input  logic [127:0] ctr_wb_i,
    output logic         start_o,
    output logic [15:0]  addr_o,
    output logic [15:0]  len_o,
    output logic [127:0] key_o,
    output logic [127:0] ctr_o,
    output logic [7:0]   dataout_o
);

    // Configuration is frozen while a job runs; reads are always serviced.
    logic       wr_en;
    logic [7:0] rd_data;
    logic [7:0] dataout_q;
    logic [15:0] addr_q;
    logic [15:0] len_q;

    assign wr_en   = (cmd_i == CMD_WR) && (state_i == ST_IDLE);
    assign start_o = wr_en && (cmdaddr_i == REG_CTRL) && (cmddata_i == START_CODE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            len_q  <= '0;
        end else if (wr_en) begin
            if (cmdaddr_i == REG_ADDR_LO) addr_q[7:0]  <= cmddata_i;
            if (cmdaddr_i == REG_ADDR_HI) addr_q[15:8] <= cmddata_i;
            if (cmdaddr_i == REG_LEN_LO)  len_q[7:0]   <= cmddata_i;
            if (cmdaddr_i == REG_LEN_HI)  len_q[15:8]  <= cmddata_i;
        end
    end

    // Key and counter byte lanes; byte i maps to bits [8i+7:8i].
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        logic [7:0] key_byte_q;
        logic [7:0] ctr_byte_q;
        logic       lane_sel;

        assign lane_sel = (cmdaddr_i[3:0] == 4'(gi));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                key_byte_q <= '0;
            end else if (wr_en && in_window(cmdaddr_i, REG_KEY_BASE) && lane_sel) begin
                key_byte_q <= cmddata_i;
            end
        end

        // Write-back only happens outside IDLE, bus writes only in IDLE,
        // so the two sources are mutually exclusive.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ctr_byte_q <= '0;
            end else if (ctr_wb_en_i) begin
                ctr_byte_q <= ctr_wb_i[8*gi +: 8];
            end else if (wr_en && in_window(cmdaddr_i, REG_CTR_BASE) && lane_sel) begin
                ctr_byte_q <= cmddata_i;
            end
        end

        assign key_o[8*gi +: 8] = key_byte_q;
        assign ctr_o[8*gi +: 8] = ctr_byte_q;
    end

    always_comb begin
        rd_data = 8'h00;
        if (cmdaddr_i == REG_CTRL)                rd_data = {6'b0, state_i};
        else if (cmdaddr_i == REG_ADDR_LO)        rd_data = addr_q[7:0];
        else if (cmdaddr_i == REG_ADDR_HI)        rd_data = addr_q[15:8];
        else if (cmdaddr_i == REG_LEN_LO)         rd_data = len_q[7:0];
        else if (cmdaddr_i == REG_LEN_HI)         rd_data = len_q[15:8];
        else if (in_window(cmdaddr_i, REG_KEY_BASE)) rd_data = key_o[{cmdaddr_i[3:0], 3'b000} +: 8];
        else if (in_window(cmdaddr_i, REG_CTR_BASE)) rd_data = ctr_o[{cmdaddr_i[3:0], 3'b000} +: 8];
    end

    // Anything but a read returns zero on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataout_q <= 8'h00;
        end else begin
            dataout_q <= (cmd_i == CMD_RD) ? rd_data : 8'h00;
        end
    end

    assign addr_o    = addr_q;
    assign len_o     = len_q;
    assign dataout_o = dataout_q;

endmodule

// File: rtl/aes_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// aes_cmd_ctrl
// Register-programmed job controller for a block-based AES datapath.
// A start command splits the programmed length into ceil(len/BLK_BYTES)
// blocks and issues one request per block (address, counter, key), waiting
// for the datapath's completion pulse before advancing.
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-low reset
//   bus   aes_cmd_ctrl_if.slave: register bus plus block request channel
// ---------------------------------------------------------------------------
module aes_cmd_ctrl #(
    parameter int BLK_BYTES = aes_cmd_ctrl_pkg::BLK_BYTES
) (
    input  logic           clk,
    input  logic           rst,
    aes_cmd_ctrl_if.slave  bus
);
    import aes_cmd_ctrl_pkg::*;

    localparam logic [15:0] ADDR_STEP = 16'(BLK_BYTES);
    localparam logic [16:0] BLK_W     = 17'(BLK_BYTES);

    state_t        state_q;
    logic          blk_valid_q;
    logic [15:0]   cur_addr_q;
    logic [127:0]  cur_ctr_q;
    logic [16:0]   remaining_q;

    logic          start;
    logic [15:0]   reg_addr;
    logic [15:0]   reg_len;
    logic [127:0]  reg_key;
    logic [127:0]  reg_ctr;

    logic [16:0]   blocks_d;
    logic [16:0]   remaining_d;
    logic [127:0]  ctr_d;

    aes_cmd_regs u_regs (
        .clk         (clk),
        .rst         (rst),
        .cmd_i       (bus.cmd),
        .cmdaddr_i   (bus.cmdaddr),
        .cmddata_i   (bus.cmddata),
        .state_i     (state_q),
        .ctr_wb_en_i (state_q == ST_ADVANCE),
        .ctr_wb_i    (ctr_d),
        .start_o     (start),
        .addr_o      (reg_addr),
        .len_o       (reg_len),
        .key_o       (reg_key),
        .ctr_o       (reg_ctr),
        .dataout_o   (bus.dataout)
    );

    // Widened to 17 bits so len=0xffff rounds up without overflow.
    assign blocks_d    = ({1'b0, reg_len} + BLK_W - 17'd1) / BLK_W;
    assign remaining_d = remaining_q - 17'd1;
    assign ctr_d       = cur_ctr_q + 128'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            blk_valid_q <= 1'b0;
            cur_addr_q  <= '0;
            cur_ctr_q   <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A zero-length start is accepted but does nothing.
                    if (start && (reg_len != 16'd0)) begin
                        state_q     <= ST_REQ;
                        blk_valid_q <= 1'b1;
                        cur_addr_q  <= reg_addr;
                        cur_ctr_q   <= reg_ctr;
                        remaining_q <= blocks_d;
                    end
                end
                ST_REQ: begin
                    if (bus.blk_ready) begin
                        state_q     <= ST_OPERATE;
                        blk_valid_q <= 1'b0;
                    end
                end
                ST_OPERATE: begin
                    if (bus.blk_done) begin
                        state_q <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    cur_addr_q  <= cur_addr_q + ADDR_STEP;
                    cur_ctr_q   <= ctr_d;
                    remaining_q <= remaining_d;
                    if (remaining_d != 17'd0) begin
                        state_q     <= ST_REQ;
                        blk_valid_q <= 1'b1;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    blk_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_addr  = cur_addr_q;
    assign bus.blk_ctr   = cur_ctr_q;
    assign bus.blk_key   = reg_key;

endmodule

// File: tb/tb_aes_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_cmd_ctrl
// Directed bench for aes_cmd_ctrl. A transaction-level model (register
// bytes, a queue of expected blocks, job phase flags) is compared with the
// DUT on every falling edge; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_aes_cmd_ctrl;
    import aes_cmd_ctrl_pkg::*;

    localparam int TB_BLK = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_cmd_ctrl_if ifc ();

    aes_cmd_ctrl #(.BLK_BYTES(TB_BLK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [15:0]  addr;
        logic [127:0] ctr;
    } blk_t;

    blk_t        m_q[$];      // blocks still to be requested
    blk_t        acc_log[$];  // blocks the DUT presented when accepted
    blk_t        m_cur;
    logic [7:0]  m_key [16];
    logic [7:0]  m_ctr [16];
    logic [15:0] m_addr, m_len;
    bit          m_busy, m_inflight, m_gap, m_rd_valid;
    logic [7:0]  m_rd_exp;

    logic resp_done  = 1'b0;
    logic stray_done = 1'b0;
    int   done_lat   = 3;
    assign ifc.blk_done = resp_done | stray_done;

    function automatic logic [127:0] key_vec();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = m_key[i];
        return v;
    endfunction

    function automatic logic [127:0] ctr_vec();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = m_ctr[i];
        return v;
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        if (a == 16'hff00) begin
            if (!m_busy)        return 8'd0;
            else if (m_gap)     return 8'd3;
            else if (m_inflight) return 8'd2;
            else                return 8'd1;
        end
        if (a == 16'hff02) return m_addr[7:0];
        if (a == 16'hff03) return m_addr[15:8];
        if (a == 16'hff04) return m_len[7:0];
        if (a == 16'hff05) return m_len[15:8];
        if (a[15:4] == 12'hff1) return m_key[a[3:0]];
        if (a[15:4] == 12'hff2) return m_ctr[a[3:0]];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_key[i] = 8'h00;
            m_ctr[i] = 8'h00;
        end
        m_addr = '0; m_len = '0;
        m_busy = 0; m_inflight = 0; m_gap = 0;
        m_rd_valid = 1; m_rd_exp = 8'h00;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        int n;
        if (a == 16'hff00) begin
            if (d == 8'h01 && m_len != 16'd0) begin
                n = (int'(m_len) + TB_BLK - 1) / TB_BLK;
                for (int i = 0; i < n; i++)
                    m_q.push_back('{addr: m_addr + 16'(i * TB_BLK), ctr: ctr_vec() + 128'(i)});
                m_busy = 1;
            end
        end
        else if (a == 16'hff02) m_addr[7:0]  = d;
        else if (a == 16'hff03) m_addr[15:8] = d;
        else if (a == 16'hff04) m_len[7:0]   = d;
        else if (a == 16'hff05) m_len[15:8]  = d;
        else if (a[15:4] == 12'hff1) m_key[a[3:0]] = d;
        else if (a[15:4] == 12'hff2) m_ctr[a[3:0]] = d;
    endtask

    // Compare on every falling edge, then advance the model to the next edge.
    always @(negedge clk) begin
        bit ev, cur_busy;
        logic [127:0] nv;
        if (!rst) begin
            chk("rst_blk_valid", ifc.blk_valid, 1'b0);
            chk("rst_dataout", ifc.dataout, 8'h00);
            model_reset();
        end else begin
            ev = m_busy && !m_inflight && !m_gap && (m_q.size() > 0);
            chk("blk_valid", ifc.blk_valid, ev);
            chk("blk_key", ifc.blk_key, key_vec());
            if (ev) begin
                chk("blk_addr", ifc.blk_addr, m_q[0].addr);
                chk("blk_ctr", ifc.blk_ctr, m_q[0].ctr);
            end
            if (m_rd_valid) chk("dataout", ifc.dataout, m_rd_exp);

            cur_busy = m_busy;
            if (ifc.cmd == CMD_RD) begin
                m_rd_valid = 1; m_rd_exp = m_read(ifc.cmdaddr);
            end else if (ifc.cmd == CMD_WR) begin
                m_rd_valid = 0;
            end else begin
                m_rd_valid = 1; m_rd_exp = 8'h00;
            end

            if (m_gap) begin
                m_gap = 0;
                nv = m_cur.ctr + 128'd1;
                for (int i = 0; i < 16; i++) m_ctr[i] = nv[8*i +: 8];
                if (m_q.size() == 0) m_busy = 0;
            end else if (ev && ifc.blk_ready) begin
                m_cur = m_q.pop_front();
                m_inflight = 1;
                acc_log.push_back('{addr: ifc.blk_addr, ctr: ifc.blk_ctr});
            end else if (m_inflight && ifc.blk_done) begin
                m_inflight = 0;
                m_gap = 1;
            end

            if (ifc.cmd == CMD_WR && !cur_busy) model_write(ifc.cmdaddr, ifc.cmddata);
        end
    end

    // Datapath responder: completion pulse done_lat cycles after accept.
    always begin
        bit acc;
        int dcnt;
        @(negedge clk);
        acc = ifc.blk_valid && ifc.blk_ready && rst;
        @(posedge clk);
        #1;
        resp_done = 1'b0;
        if (!rst) dcnt = 0;
        else if (acc) dcnt = done_lat;
        else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) resp_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        ifc.cmd = CMD_WR; ifc.cmdaddr = a; ifc.cmddata = d;
        tick();
        ifc.cmd = CMD_NOP;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        ifc.cmd = CMD_RD; ifc.cmdaddr = a;
        tick();
        ifc.cmd = CMD_NOP;
        @(negedge clk);
        d = ifc.dataout;
        tick();
        chk(name, d, exp);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] l,
                        input logic [127:0] c, input logic [7:0] kb);
        wr(16'hff02, a[7:0]);
        wr(16'hff03, a[15:8]);
        wr(16'hff04, l[7:0]);
        wr(16'hff05, l[15:8]);
        for (int i = 0; i < 16; i++) begin
            wr(16'hff10 + 16'(i), kb + 8'(i));
            wr(16'hff20 + 16'(i), c[8*i +: 8]);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && m_busy; i++) tick();
        chk("job_finished", m_busy, 1'b0);
    endtask

    task automatic wait_inflight();
        for (int i = 0; i < 100 && !m_inflight; i++) tick();
        chk("block_accepted", m_inflight, 1'b1);
    endtask

    task automatic start_job();
        acc_log.delete();
        wr(16'hff00, 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        ifc.cmd = CMD_NOP; ifc.cmdaddr = '0; ifc.cmddata = '0; ifc.blk_ready = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Reset state
        chk("reset_valid", ifc.blk_valid, 1'b0);
        chk("reset_dataout", ifc.dataout, 8'h00);
        rd_chk("reset_status", 16'hff00, 8'h00);
        rd_chk("reset_key0", 16'hff10, 8'h00);
        rd_chk("reset_ctr0", 16'hff20, 8'h00);

        // Two-block job
        load(16'h1000, 16'h0020, 128'h0, 8'ha0);
        start_job();
        wait_idle();
        chk("a_nblk", acc_log.size(), 2);
        chk("a0_addr", acc_log[0].addr, 16'h1000);
        chk("a0_ctr", acc_log[0].ctr, 128'h0);
        chk("a1_addr", acc_log[1].addr, 16'h1010);
        chk("a1_ctr", acc_log[1].ctr, 128'h1);
        rd_chk("a_status", 16'hff00, 8'h00);
        rd_chk("a_ctr0", 16'hff20, 8'h02);
        rd_chk("a_addr_hi", 16'hff03, 8'h10);

        // Length not a multiple of the block size rounds up
        wr(16'hff04, 8'h11);
        start_job();
        wait_idle();
        chk("b_nblk", acc_log.size(), 2);
        chk("b0_ctr", acc_log[0].ctr, 128'h2);
        chk("b1_addr", acc_log[1].addr, 16'h1010);
        chk("b1_ctr", acc_log[1].ctr, 128'h3);
        rd_chk("b_ctr0", 16'hff20, 8'h04);

        // Zero length, wrong start code, stray done while idle
        wr(16'hff04, 8'h00);
        start_job();
        repeat (8) tick();
        chk("c_zero_len_nblk", acc_log.size(), 0);
        rd_chk("c_status", 16'hff00, 8'h00);
        stray_done = 1'b1; tick(); stray_done = 1'b0;
        wr(16'hff04, 8'h10);
        wr(16'hff00, 8'h03);
        repeat (5) tick();
        chk("c_bad_start_nblk", acc_log.size(), 0);
        rd_chk("c_status2", 16'hff00, 8'h00);

        // Back-pressure: request held while ready is low
        ifc.blk_ready = 1'b0;
        start_job();
        repeat (5) tick();
        rd_chk("d_status_req", 16'hff00, 8'h01);
        chk("d_valid_held", ifc.blk_valid, 1'b1);
        stray_done = 1'b1; tick(); stray_done = 1'b0;
        ifc.blk_ready = 1'b1;
        wait_idle();
        chk("d_nblk", acc_log.size(), 1);
        chk("d0_addr", acc_log[0].addr, 16'h1000);
        chk("d0_ctr", acc_log[0].ctr, 128'h4);

        // Address and counter wrap
        load(16'hfff0, 16'h0020, {128{1'b1}}, 8'h30);
        start_job();
        wait_idle();
        chk("e0_addr", acc_log[0].addr, 16'hfff0);
        chk("e0_ctr", acc_log[0].ctr, {128{1'b1}});
        chk("e1_addr", acc_log[1].addr, 16'h0000);
        chk("e1_ctr", acc_log[1].ctr, 128'h0);
        rd_chk("e_ctr0", 16'hff20, 8'h01);
        rd_chk("e_ctr15", 16'hff2f, 8'h00);

        // Writes during OPERATE are ignored; reads still work
        done_lat = 20;
        load(16'h1000, 16'h0010, 128'h0, 8'ha0);
        start_job();
        wait_inflight();
        wr(16'hff10, 8'h55);
        wr(16'hff02, 8'h77);
        wr(16'hff00, 8'h01);
        rd_chk("f_status_op", 16'hff00, 8'h02);
        rd_chk("f_unmapped_ff01", 16'hff01, 8'h00);
        rd_chk("f_unmapped_1234", 16'h1234, 8'h00);
        wait_idle();
        done_lat = 3;
        chk("f_nblk", acc_log.size(), 1);
        rd_chk("f_key0", 16'hff10, 8'ha0);
        rd_chk("f_addr_lo", 16'hff02, 8'h00);
        rd_chk("f_ctr0", 16'hff20, 8'h01);

        // Reset while requesting: valid drops at once
        ifc.blk_ready = 1'b0;
        start_job();
        repeat (2) tick();
        chk("g_valid_before", ifc.blk_valid, 1'b1);
        #2 rst = 1'b0;
        #1 chk("g_valid_in_reset", ifc.blk_valid, 1'b0);
        tick();
        rst = 1'b1;
        ifc.blk_ready = 1'b1;
        tick();
        rd_chk("g_status", 16'hff00, 8'h00);
        rd_chk("g_ctr0", 16'hff20, 8'h00);

        // Reset during OPERATE abandons the job; next job runs cleanly
        load(16'h2000, 16'h0020, 128'h5, 8'h10);
        start_job();
        wait_inflight();
        #2 rst = 1'b0;
        #1 chk("h_valid_in_reset", ifc.blk_valid, 1'b0);
        chk("h_dataout_in_reset", ifc.dataout, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        rd_chk("h_status", 16'hff00, 8'h00);
        repeat (8) tick();
        chk("h_no_new_blocks", acc_log.size(), 1);
        load(16'h2000, 16'h0010, 128'h5, 8'h10);
        start_job();
        wait_idle();
        chk("h_nblk", acc_log.size(), 1);
        chk("h0_addr", acc_log[0].addr, 16'h2000);
        chk("h0_ctr", acc_log[0].ctr, 128'h5);
        rd_chk("h_ctr0", 16'hff20, 8'h06);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
